// File: rtl/spim_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spim_xfer_pkg
//  Brief    : Shared encodings for the SPI master transaction sequencer and
//             the byte engine it drives.
//  Revision : 1.0  initial release
// ============================================================================
package spim_xfer_pkg;

    // Byte-engine operation codes
    typedef enum logic [1:0] {
        Oper_None  = 2'd0,
        Oper_Write = 2'd1,
        Oper_Read  = 2'd2,
        Oper_Dummy = 2'd3
    } oper_t;

    // Bus width used by the engine for a phase
    typedef enum logic [1:0] {
        PhaseMode_1bit = 2'd0,
        PhaseMode_2bit = 2'd1,
        PhaseMode_4bit = 2'd2
    } phase_mode_t;

    // Largest address phase the sequencer will ever emit
    localparam int c_MAX_ADDR_BYTES = 4;

    // Limit a requested address byte count to what the address register holds
    function automatic logic [2:0] clamp_addr_bytes(input logic [2:0] n,
                                                    input logic [2:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spim_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : spim_xfer
//  Brief    : Flash-style transaction sequencer. Walks the instruction,
//             address, dummy and data phases as a series of byte-engine
//             operations, owns chip-select and bridges the TX/RX streams.
//  Revision : 1.0  initial release
// ============================================================================
module spim_xfer
    import spim_xfer_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int CS_IDLE = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              cfg_inst_en,
    input  logic [7:0]        cfg_inst,
    input  logic [1:0]        cfg_inst_mode,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [2:0]        cfg_addr_bytes,
    input  logic [1:0]        cfg_addr_mode,
    input  logic [4:0]        cfg_dummy,
    input  logic [1:0]        cfg_data_mode,
    input  logic              cfg_data_dir,
    input  logic [LEN_W-1:0]  cfg_data_len,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              eng_clr_n,
    output logic [1:0]        eng_boper,
    output logic [1:0]        eng_bmode,
    output logic [7:0]        eng_tbyte,
    output logic [4:0]        eng_dummy,
    input  logic [7:0]        eng_rbyte,
    input  logic              eng_bdone,
    output logic              spi_cs_n
);

    localparam int c_ADDR_BYTES = (ADDR_W / 8 > c_MAX_ADDR_BYTES) ? c_MAX_ADDR_BYTES : ADDR_W / 8;
    localparam int c_HOLD_W     = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_INST     = 3'd2,
        S_ADDR     = 3'd3,
        S_DUMMY    = 3'd4,
        S_DATA     = 3'd5,
        S_CS_HOLD  = 3'd6
    } state_t;

    state_t              r_state;
    logic                r_wait;       // op issued, engine has not reported bdone yet
    logic                r_inst_en;
    logic [7:0]          r_inst;
    logic [1:0]          r_inst_mode;
    logic [ADDR_W-1:0]   r_addr_sh;    // next address byte always sits in the top 8 bits
    logic [2:0]          r_addr_cnt;
    logic [1:0]          r_addr_mode;
    logic [4:0]          r_dummy;
    logic [1:0]          r_data_mode;
    logic                r_data_dir;
    logic [LEN_W-1:0]    r_len;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic [2:0]          w_abytes;
    logic [5:0]          w_addr_shift;
    state_t              w_after_dummy;
    state_t              w_after_addr;
    state_t              w_after_inst;
    state_t              w_after_setup;
    logic                w_bdone;
    logic                w_issue;
    oper_t               w_op;
    logic [7:0]          w_byte;
    logic [1:0]          w_mode;
    logic                w_phase_end;
    state_t              w_adv_state;

    // Left-align the requested address bytes so they leave MSB first
    assign w_abytes     = clamp_addr_bytes(cfg_addr_bytes, 3'(c_ADDR_BYTES));
    assign w_addr_shift = 6'(ADDR_W) - {w_abytes, 3'b000};

    // Skip chain: each phase falls through to the next enabled one
    assign w_after_dummy = (r_len != '0)        ? S_DATA  : S_CS_HOLD;
    assign w_after_addr  = (r_dummy != 5'd0)    ? S_DUMMY : w_after_dummy;
    assign w_after_inst  = (r_addr_cnt != 3'd0) ? S_ADDR  : w_after_addr;
    assign w_after_setup = r_inst_en            ? S_INST  : w_after_inst;

    // Per-phase op selection, issue permission and phase-complete detection
    always_comb begin
        w_bdone     = r_wait && eng_bdone;
        w_issue     = 1'b0;
        w_op        = Oper_None;
        w_byte      = 8'h00;
        w_mode      = PhaseMode_1bit;
        w_phase_end = 1'b0;
        w_adv_state = r_state;
        case (r_state)
            S_CS_SETUP: begin
                w_phase_end = 1'b1;
                w_adv_state = w_after_setup;
            end
            S_INST: begin
                w_issue     = !r_wait;
                w_op        = Oper_Write;
                w_byte      = r_inst;
                w_mode      = r_inst_mode;
                w_phase_end = w_bdone;
                w_adv_state = w_after_inst;
            end
            S_ADDR: begin
                w_issue     = !r_wait;
                w_op        = Oper_Write;
                w_byte      = r_addr_sh[ADDR_W-1 -: 8];
                w_mode      = r_addr_mode;
                w_phase_end = w_bdone && (r_addr_cnt == 3'd1);
                w_adv_state = w_after_addr;
            end
            S_DUMMY: begin
                w_issue     = !r_wait;
                w_op        = Oper_Dummy;
                w_mode      = r_data_mode;
                w_phase_end = w_bdone;
                w_adv_state = w_after_dummy;
            end
            S_DATA: begin
                w_mode      = r_data_mode;
                w_adv_state = S_CS_HOLD;
                if (r_data_dir) begin
                    // A new read waits until the previous byte has been handed off
                    w_op        = Oper_Read;
                    w_issue     = !r_wait && !rx_valid && (r_len != '0);
                    w_phase_end = !r_wait && rx_valid && rx_ready && (r_len == '0);
                end else begin
                    w_op        = Oper_Write;
                    w_byte      = tx_data;
                    w_issue     = !r_wait && tx_valid && (r_len != '0);
                    w_phase_end = w_bdone && (r_len == LEN_W'(1));
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM with registered engine, stream and chip-select outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait      <= 1'b0;
            r_inst_en   <= 1'b0;
            r_inst      <= 8'h00;
            r_inst_mode <= 2'd0;
            r_addr_sh   <= '0;
            r_addr_cnt  <= 3'd0;
            r_addr_mode <= 2'd0;
            r_dummy     <= 5'd0;
            r_data_mode <= 2'd0;
            r_data_dir  <= 1'b0;
            r_len       <= '0;
            r_hold_cnt  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_ready    <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            eng_clr_n   <= 1'b1;
            eng_boper   <= Oper_None;
            eng_bmode   <= PhaseMode_1bit;
            eng_tbyte   <= 8'h00;
            eng_dummy   <= 5'd0;
            spi_cs_n    <= 1'b1;
        end else begin
            done      <= 1'b0;
            tx_ready  <= 1'b0;
            eng_clr_n <= 1'b1;
            eng_boper <= Oper_None;

            if (start && (r_state == S_IDLE)) begin
                r_inst_en   <= cfg_inst_en;
                r_inst      <= cfg_inst;
                r_inst_mode <= cfg_inst_mode;
                r_addr_sh   <= cfg_addr << w_addr_shift;
                r_addr_cnt  <= w_abytes;
                r_addr_mode <= cfg_addr_mode;
                r_dummy     <= cfg_dummy;
                r_data_mode <= cfg_data_mode;
                r_data_dir  <= cfg_data_dir;
                r_len       <= cfg_data_len;
                r_wait      <= 1'b0;
                busy        <= 1'b1;
                spi_cs_n    <= 1'b0;
                r_state     <= S_CS_SETUP;
            end else if (abort && (r_state != S_IDLE) && (r_state != S_CS_HOLD)) begin
                // Hold already ends the transaction, so abort only matters before it
                eng_clr_n  <= 1'b0;
                rx_valid   <= 1'b0;
                r_wait     <= 1'b0;
                spi_cs_n   <= 1'b1;
                done       <= 1'b1;
                r_hold_cnt <= c_HOLD_W'(CS_IDLE - 1);
                r_state    <= S_CS_HOLD;
            end else begin
                if (w_issue) begin
                    eng_boper <= w_op;
                    eng_bmode <= w_mode;
                    eng_tbyte <= w_byte;
                    eng_dummy <= r_dummy;
                    r_wait    <= 1'b1;
                    tx_ready  <= (r_state == S_DATA) && !r_data_dir;
                end

                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end

                if (w_bdone) begin
                    r_wait <= 1'b0;
                    if (r_state == S_ADDR) begin
                        r_addr_cnt <= r_addr_cnt - 3'd1;
                        r_addr_sh  <= r_addr_sh << 8;
                    end
                    if (r_state == S_DATA) begin
                        r_len <= r_len - LEN_W'(1);
                        if (r_data_dir) begin
                            rx_data  <= eng_rbyte;
                            rx_valid <= 1'b1;
                        end
                    end
                end

                if (w_phase_end) begin
                    r_state <= w_adv_state;
                    if (w_adv_state == S_CS_HOLD) begin
                        spi_cs_n   <= 1'b1;
                        done       <= 1'b1;
                        r_hold_cnt <= c_HOLD_W'(CS_IDLE - 1);
                    end
                end

                if (r_state == S_CS_HOLD) begin
                    if (r_hold_cnt == '0) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spim_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spim_xfer
//  Brief    : Scoreboard bench for spim_xfer with a behavioural byte engine,
//             TX producer and RX consumer.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spim_xfer;
    import spim_xfer_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 16;
    localparam int CS_IDLE = 2;

    logic        clk, rst_n, start, abort, busy, done;
    logic        cfg_inst_en;
    logic [7:0]  cfg_inst;
    logic [1:0]  cfg_inst_mode;
    logic [31:0] cfg_addr;
    logic [2:0]  cfg_addr_bytes;
    logic [1:0]  cfg_addr_mode;
    logic [4:0]  cfg_dummy;
    logic [1:0]  cfg_data_mode;
    logic        cfg_data_dir;
    logic [15:0] cfg_data_len;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        eng_clr_n;
    logic [1:0]  eng_boper, eng_bmode;
    logic [7:0]  eng_tbyte;
    logic [4:0]  eng_dummy;
    logic [7:0]  eng_rbyte;
    logic        eng_bdone;
    logic        spi_cs_n;

    spim_xfer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CS_IDLE(CS_IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .cfg_inst_en(cfg_inst_en), .cfg_inst(cfg_inst), .cfg_inst_mode(cfg_inst_mode),
        .cfg_addr(cfg_addr), .cfg_addr_bytes(cfg_addr_bytes), .cfg_addr_mode(cfg_addr_mode),
        .cfg_dummy(cfg_dummy), .cfg_data_mode(cfg_data_mode), .cfg_data_dir(cfg_data_dir),
        .cfg_data_len(cfg_data_len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .eng_clr_n(eng_clr_n),
        .eng_boper(eng_boper), .eng_bmode(eng_bmode), .eng_tbyte(eng_tbyte), .eng_dummy(eng_dummy),
        .eng_rbyte(eng_rbyte), .eng_bdone(eng_bdone), .spi_cs_n(spi_cs_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] b;
        logic [1:0] m;
        logic [4:0] d;
    } exp_op_t;

    exp_op_t    exp_ops[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    logic [7:0] rd_force_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    // Monitor / model state
    bit         eng_out = 1'b0;
    int         eng_cnt = 0;
    bit         eng_is_read = 1'b0;
    logic [7:0] hold_b;
    logic [1:0] hold_m;
    int done_cnt = 0, clr_cnt = 0, ops_cnt = 0, txr_cnt = 0, tx_consumed = 0;
    int tx_gap_after = -1, tx_gap_len = 0, tx_gap_cnt = 0;
    int rx_stall_first = 0, rx_hold_cnt = 0;
    int cs_low_run = 0, cs_high_run = 0, last_low_len = 0, cs_rise_cnt = 0;
    bit prev_rx_wait = 1'b0, prev_rx_valid = 1'b0;
    logic [7:0] prev_rx_data = 8'h00;

    // Engine model, TX producer, RX consumer and output monitor (all on negedge)
    initial begin
        exp_op_t e;
        eng_bdone = 1'b0;
        eng_rbyte = 8'h00;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        forever begin
            @(negedge clk);
            eng_bdone = 1'b0;
            if (rst_n) begin
                // chip-select windows
                if (spi_cs_n) begin
                    if (cs_low_run > 0) begin
                        last_low_len = cs_low_run;
                        cs_low_run   = 0;
                        cs_rise_cnt++;
                    end
                    cs_high_run++;
                end else begin
                    if (cs_high_run > 0) begin
                        check("cs_high_gap", 64'(cs_high_run >= CS_IDLE), 1);
                        cs_high_run = 0;
                    end
                    cs_low_run++;
                end

                if (done) begin
                    done_cnt++;
                    check("busy_at_done", busy, 1);
                end

                // engine
                if (!eng_clr_n) begin
                    clr_cnt++;
                    eng_out = 1'b0;
                end else if (eng_boper != Oper_None) begin
                    ops_cnt++;
                    check("op_cs_low", spi_cs_n, 0);
                    check("op_while_busy", eng_out, 0);
                    if (exp_ops.size() == 0) begin
                        check("unexpected_op", eng_boper, Oper_None);
                    end else begin
                        e = exp_ops.pop_front();
                        check("op_kind", eng_boper, e.op);
                        if (e.op == Oper_Write) check("op_tbyte", eng_tbyte, e.b);
                        if (e.op != Oper_Dummy) check("op_bmode", eng_bmode, e.m);
                        if (e.op == Oper_Dummy) check("op_dummy", eng_dummy, e.d);
                    end
                    if (eng_boper == Oper_Read) check("read_while_rx_valid", rx_valid, 0);
                    if (tx_ready) check("tx_valid_at_issue", tx_valid, 1);
                    eng_out     = 1'b1;
                    eng_cnt     = int'($urandom_range(1, 4));
                    eng_is_read = (eng_boper == Oper_Read);
                    hold_b      = eng_tbyte;
                    hold_m      = eng_bmode;
                end else if (eng_out) begin
                    check("tbyte_stable", eng_tbyte, hold_b);
                    check("bmode_stable", eng_bmode, hold_m);
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_out   = 1'b0;
                        eng_bdone = 1'b1;
                        if (eng_is_read) begin
                            if (rd_force_q.size() > 0) eng_rbyte = rd_force_q.pop_front();
                            else                       eng_rbyte = 8'($urandom);
                            exp_rx.push_back(eng_rbyte);
                        end
                    end
                end

                // TX producer
                if (tx_ready) begin
                    txr_cnt++;
                    check("tx_ready_with_write", eng_boper, Oper_Write);
                    if (tx_q.size() == 0) begin
                        check("tx_ready_extra", tx_ready, 0);
                    end else begin
                        void'(tx_q.pop_front());
                        tx_consumed++;
                        if (tx_consumed == tx_gap_after) tx_gap_cnt = tx_gap_len;
                        else                             tx_gap_cnt = int'($urandom_range(0, 1));
                    end
                end
                if (tx_gap_cnt > 0) begin
                    tx_gap_cnt--;
                    tx_valid = 1'b0;
                end else if (tx_q.size() > 0) begin
                    tx_valid = 1'b1;
                    tx_data  = tx_q[0];
                end else begin
                    tx_valid = 1'b0;
                end

                // RX consumer
                if (prev_rx_wait && rx_valid) check("rx_data_stable", rx_data, prev_rx_data);
                if (rx_valid && !prev_rx_valid && rx_stall_first > 0) begin
                    rx_hold_cnt    = rx_stall_first;
                    rx_stall_first = 0;
                end
                if (rx_hold_cnt > 0) begin
                    rx_hold_cnt--;
                    rx_ready = 1'b0;
                end else begin
                    rx_ready = 1'($urandom_range(0, 1));
                end
                if (rx_valid && rx_ready) begin
                    if (exp_rx.size() == 0) check("rx_unexpected", rx_valid, 0);
                    else                    check("rx_data", rx_data, exp_rx.pop_front());
                end
                prev_rx_wait  = rx_valid && !rx_ready;
                prev_rx_valid = rx_valid;
                prev_rx_data  = rx_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        done_cnt = 0; clr_cnt = 0; ops_cnt = 0; txr_cnt = 0; tx_consumed = 0; cs_rise_cnt = 0;
    endtask

    task automatic scramble_cfg();
        cfg_inst_en = 1'($urandom); cfg_inst = 8'($urandom); cfg_inst_mode = 2'($urandom);
        cfg_addr = $urandom; cfg_addr_bytes = 3'($urandom); cfg_addr_mode = 2'($urandom);
        cfg_dummy = 5'($urandom); cfg_data_mode = 2'($urandom); cfg_data_dir = 1'($urandom);
        cfg_data_len = 16'($urandom);
    endtask

    task automatic push_header(input bit ie, input logic [7:0] inst, input logic [1:0] im,
                               input logic [31:0] addr, input logic [2:0] ab, input logic [1:0] am,
                               input logic [4:0] dmy, input logic [1:0] dm);
        int n;
        if (ie) exp_ops.push_back('{op: Oper_Write, b: inst, m: im, d: 5'd0});
        n = (ab > 3'd4) ? 4 : int'(ab);
        for (int i = n - 1; i >= 0; i--)
            exp_ops.push_back('{op: Oper_Write, b: addr[8*i +: 8], m: am, d: 5'd0});
        if (dmy != 5'd0) exp_ops.push_back('{op: Oper_Dummy, b: 8'h00, m: dm, d: dmy});
    endtask

    task automatic run_xfer(input bit ie, input logic [7:0] inst, input logic [1:0] im,
                            input logic [31:0] addr, input logic [2:0] ab, input logic [1:0] am,
                            input logic [4:0] dmy, input logic [1:0] dm, input bit dir,
                            input logic [15:0] len, input int gap_after, input int gap_len,
                            input int stall, input int exp_low, input bit abort_too);
        int t;
        logic [7:0] b;
        clear_counts();
        tx_gap_after   = gap_after;
        tx_gap_len     = gap_len;
        rx_stall_first = stall;
        push_header(ie, inst, im, addr, ab, am, dmy, dm);
        for (int i = 0; i < int'(len); i++) begin
            if (dir) begin
                exp_ops.push_back('{op: Oper_Read, b: 8'h00, m: dm, d: 5'd0});
            end else begin
                b = 8'($urandom);
                tx_q.push_back(b);
                exp_ops.push_back('{op: Oper_Write, b: b, m: dm, d: 5'd0});
            end
        end
        cfg_inst_en = ie; cfg_inst = inst; cfg_inst_mode = im; cfg_addr = addr;
        cfg_addr_bytes = ab; cfg_addr_mode = am; cfg_dummy = dmy; cfg_data_mode = dm;
        cfg_data_dir = dir; cfg_data_len = len;
        start = 1'b1;
        abort = abort_too;
        tick();
        start = 1'b0;
        abort = 1'b0;
        scramble_cfg();
        check("busy_after_start", busy, 1);
        t = 0;
        while (done_cnt == 0 && t < 4000) begin tick(); t++; end
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        check("busy_low", busy, 0);
        check("done_count", done_cnt, 1);
        check("ops_left", exp_ops.size(), 0);
        check("rx_left", exp_rx.size(), 0);
        check("tx_ready_count", txr_cnt, dir ? 0 : int'(len));
        check("cs_n_idle", spi_cs_n, 1);
        check("cs_low_windows", cs_rise_cnt, 1);
        if (exp_low >= 0) check("cs_low_len", last_low_len, exp_low);
        exp_ops.delete();
        exp_rx.delete();
        tx_q.delete();
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        scramble_cfg();
        #22;
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_clr_n", eng_clr_n, 1);
        check("rst_boper", eng_boper, Oper_None);
        check("rst_bmode", eng_bmode, PhaseMode_1bit);
        check("rst_tbyte", eng_tbyte, 0);
        check("rst_dummy", eng_dummy, 0);
        #11 rst_n = 1'b1;
        repeat (3) tick();

        // JEDEC-ID style read
        rd_force_q.push_back(8'hEF); rd_force_q.push_back(8'h40); rd_force_q.push_back(8'h18);
        run_xfer(1, 8'h9F, PhaseMode_1bit, 32'h0, 3'd0, PhaseMode_1bit, 5'd0, PhaseMode_1bit,
                 1, 16'd3, -1, 0, 0, -1, 0);
        // quad read with address and dummy
        run_xfer(1, 8'hEB, PhaseMode_1bit, 32'h00123456, 3'd3, PhaseMode_4bit, 5'd6, PhaseMode_4bit,
                 1, 16'd2, -1, 0, 0, -1, 0);
        // write with producer gap after the second byte
        run_xfer(1, 8'h02, PhaseMode_1bit, 32'h00ABCDEF, 3'd3, PhaseMode_1bit, 5'd0, PhaseMode_1bit,
                 0, 16'd4, 2, 10, 0, -1, 0);
        // read with consumer stall
        run_xfer(1, 8'h03, PhaseMode_1bit, 32'h00000100, 3'd3, PhaseMode_1bit, 5'd0, PhaseMode_2bit,
                 1, 16'd2, -1, 0, 20, -1, 0);

        // abort during the address phase
        clear_counts();
        push_header(1, 8'h0B, PhaseMode_1bit, 32'hDEADBEEF, 3'd4, PhaseMode_1bit, 5'd0, PhaseMode_1bit);
        cfg_inst_en = 1; cfg_inst = 8'h0B; cfg_inst_mode = 0; cfg_addr = 32'hDEADBEEF;
        cfg_addr_bytes = 3'd4; cfg_addr_mode = 0; cfg_dummy = 0; cfg_data_mode = 0;
        cfg_data_dir = 1; cfg_data_len = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (ops_cnt < 2 && t < 200) begin tick(); t++; end
        check("abort_reached_addr", 64'(ops_cnt >= 2), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_ops.delete();
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        check("abort_clr_pulses", clr_cnt, 1);
        check("abort_done", done_cnt, 1);
        check("abort_busy", busy, 0);
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_rx_valid", rx_valid, 0);

        // abort while idle has no effect
        clear_counts();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check("idle_abort_clr", clr_cnt, 0);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done_cnt, 0);

        // start together with abort in idle: the start proceeds
        run_xfer(1, 8'h05, PhaseMode_1bit, 32'h0, 3'd0, PhaseMode_1bit, 5'd0, PhaseMode_1bit,
                 1, 16'd1, -1, 0, 0, -1, 1);
        // everything skipped
        run_xfer(0, 8'h00, PhaseMode_1bit, 32'h0, 3'd0, PhaseMode_1bit, 5'd0, PhaseMode_1bit,
                 0, 16'd0, -1, 0, 0, 1, 0);
        check("skip_no_ops", ops_cnt, 0);

        // randomized transactions
        for (int k = 0; k < 25; k++) begin
            run_xfer(1'($urandom), 8'($urandom), 2'($urandom_range(0, 2)), $urandom,
                     3'($urandom_range(0, 6)), 2'($urandom_range(0, 2)),
                     ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0,
                     2'($urandom_range(0, 2)), 1'($urandom), 16'($urandom_range(0, 5)),
                     -1, 0, int'($urandom_range(0, 6)), -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
